// File: rtl/bf16_pkg.sv
// Shared BF16 types and constants for the FP32->BF16 encoder and the BF16 adder wrapper.
package bf16_pkg;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  localparam logic [15:0]  BF16_POS_INF  = 16'h7F80;
  localparam logic [15:0]  BF16_NEG_INF  = 16'hFF80;
  localparam logic [7:0]   BF16_EXP_MAX  = 8'hFF;
  localparam int unsigned  BF16_QNAN_BIT = 6;

  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
    logic qnan;
    logic snan;
    logic pos_inf;
    logic neg_inf;
    logic inexact;
  } bf16_flags_t;

endpackage

// File: rtl/fp32_rne_round.sv
// Combinational FP32 classify plus round-to-nearest-even increment of the upper 16 bits.
module fp32_rne_round
  import bf16_pkg::*;
(
  input  logic [31:0] fp32,
  output logic        sign,
  output fp_class_e   cls,
  output logic [16:0] sum,
  output logic        inexact
);

  logic [7:0]  exp_f;
  logic [22:0] mant;
  logic        lsb;
  logic        guard;
  logic        sticky;
  logic        inc;

  assign sign   = fp32[31];
  assign exp_f  = fp32[30:23];
  assign mant   = fp32[22:0];
  assign lsb    = fp32[16];
  assign guard  = fp32[15];
  assign sticky = |fp32[14:0];

  // NaN payloads are truncated, so no increment is applied when exp is all-ones
  assign inc     = guard & (sticky | lsb) & (exp_f != BF16_EXP_MAX);
  assign sum     = {1'b0, fp32[31:16]} + {16'b0, inc};
  assign inexact = guard | sticky;

  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = (mant == '0) ? ZERO : DENORM;
    end else if (exp_f == BF16_EXP_MAX) begin
      if (mant == '0)   cls = INF;
      else if (mant[22]) cls = QNAN;
      else               cls = SNAN;
    end
  end

endmodule

// File: rtl/fp32_to_bf16_encoder.sv
// Two-stage FP32->BF16 narrowing converter with valid/ready handshake and inexact-event counter.
module fp32_to_bf16_encoder
  import bf16_pkg::*;
#(
  parameter bit          FLUSH_DENORM = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             zero,
  output logic             underflow,
  output logic             overflow,
  output logic             qNaN,
  output logic             sNaN,
  output logic             positive_inf,
  output logic             negative_inf,
  output logic             inexact,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_inexact
);

  logic        advance1;
  logic        advance2;

  logic        r_sign;
  fp_class_e   r_cls;
  logic [16:0] r_sum;
  logic        r_inexact;

  logic        s1_valid;
  logic        s1_sign;
  fp_class_e   s1_cls;
  logic [16:0] s1_sum;
  logic        s1_inexact;

  logic        s2_valid;
  logic [15:0] nx_data;
  bf16_flags_t nx_flags;
  bf16_flags_t flags_q;

  assign advance2  = !s2_valid | out_ready;
  assign advance1  = !s1_valid | advance2;
  assign in_ready  = advance1;
  assign out_valid = s2_valid;

  fp32_rne_round u_round (
    .fp32    (in_data),
    .sign    (r_sign),
    .cls     (r_cls),
    .sum     (r_sum),
    .inexact (r_inexact)
  );

  always_ff @(posedge clk) begin
    if (in_valid && advance1) begin
      s1_sign    <= r_sign;
      s1_cls     <= r_cls;
      s1_sum     <= r_sum;
      s1_inexact <= r_inexact;
    end
  end

  always_comb begin
    nx_data  = {s1_sign, s1_sum[14:0]};
    nx_flags = '0;
    unique case (s1_cls)
      ZERO: begin
        nx_data       = {s1_sign, 15'h0};
        nx_flags.zero = 1'b1;
      end
      DENORM: begin
        if (FLUSH_DENORM) begin
          nx_data            = {s1_sign, 15'h0};
          nx_flags.zero      = 1'b1;
          nx_flags.underflow = 1'b1;
          nx_flags.inexact   = 1'b1;
        end else begin
          nx_flags.zero      = (s1_sum[14:0] == '0);
          nx_flags.underflow = s1_inexact;
          nx_flags.inexact   = s1_inexact;
        end
      end
      NORMAL: begin
        nx_flags.inexact = s1_inexact;
        if (s1_sum[14:7] == BF16_EXP_MAX) begin
          nx_data           = s1_sign ? BF16_NEG_INF : BF16_POS_INF;
          nx_flags.overflow = 1'b1;
          nx_flags.inexact  = 1'b1;
          nx_flags.pos_inf  = !s1_sign;
          nx_flags.neg_inf  = s1_sign;
        end
      end
      INF: begin
        nx_data          = s1_sign ? BF16_NEG_INF : BF16_POS_INF;
        nx_flags.pos_inf = !s1_sign;
        nx_flags.neg_inf = s1_sign;
      end
      QNAN: begin
        nx_data       = {s1_sign, BF16_EXP_MAX, s1_sum[6:0]};
        nx_flags.qnan = 1'b1;
      end
      SNAN: begin
        nx_data                = {s1_sign, BF16_EXP_MAX, s1_sum[6:0]};
        nx_data[BF16_QNAN_BIT] = 1'b1;
        nx_flags.snan          = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_data    <= '0;
      flags_q     <= '0;
      cnt_inexact <= '0;
    end else begin
      if (advance1) s1_valid <= in_valid;
      if (advance2) s2_valid <= s1_valid;
      if (advance2 && s1_valid) begin
        out_data <= nx_data;
        flags_q  <= nx_flags;
      end
      if (cnt_clr)
        cnt_inexact <= '0;
      else if (s2_valid && out_ready && flags_q.inexact && !(&cnt_inexact))
        cnt_inexact <= cnt_inexact + 1'b1;
    end
  end

  assign zero         = flags_q.zero;
  assign underflow    = flags_q.underflow;
  assign overflow     = flags_q.overflow;
  assign qNaN         = flags_q.qnan;
  assign sNaN         = flags_q.snan;
  assign positive_inf = flags_q.pos_inf;
  assign negative_inf = flags_q.neg_inf;
  assign inexact      = flags_q.inexact;

endmodule

// File: tb/tb_fp32_to_bf16_encoder.sv
// Table-driven scoreboard bench for fp32_to_bf16_encoder (FLUSH_DENORM=1, CNT_W=16).
module tb_fp32_to_bf16_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf, inexact;
  logic        cnt_clr;
  logic [15:0] cnt_inexact;

  fp32_to_bf16_encoder #(.FLUSH_DENORM(1'b1), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .zero         (zero),
    .underflow    (underflow),
    .overflow     (overflow),
    .qNaN         (qNaN),
    .sNaN         (sNaN),
    .positive_inf (positive_inf),
    .negative_inf (negative_inf),
    .inexact      (inexact),
    .cnt_clr      (cnt_clr),
    .cnt_inexact  (cnt_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {zero, underflow, overflow, qNaN, sNaN, +inf, -inf, inexact}
  typedef struct {
    logic [31:0] in;
    logic [15:0] d;
    logic [7:0]  f;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  f;
  } exp_t;

  vec_t        tbl[17];
  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_cnt = 0;
  logic [15:0] held;

  function automatic logic [7:0] dut_flags();
    return {zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf, inexact};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {16'h0, out_data}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", {16'h0, out_data}, {16'h0, e.d});
        chk("flags", {24'h0, dut_flags()}, {24'h0, e.f});
        if (e.f[0]) exp_cnt++;
      end
    end
  end

  task automatic send(input vec_t v);
    int unsigned n;
    logic done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = v.in;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: v.d, f: v.f});
        done = 1'b1;
      end else if (n > 50) begin
        chk("in_ready_timeout", 32'h0, 32'h1);
        done = 1'b1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{32'h3F800000, 16'h3F80, 8'b0000_0000};
    tbl[1]  = '{32'h3F808000, 16'h3F80, 8'b0000_0001};
    tbl[2]  = '{32'h3F818000, 16'h3F82, 8'b0000_0001};
    tbl[3]  = '{32'h3F808001, 16'h3F81, 8'b0000_0001};
    tbl[4]  = '{32'h7F7FFFFF, 16'h7F80, 8'b0010_0101};
    tbl[5]  = '{32'hFF800000, 16'hFF80, 8'b0000_0010};
    tbl[6]  = '{32'h7FC00001, 16'h7FC0, 8'b0001_0000};
    tbl[7]  = '{32'h7FA00000, 16'h7FE0, 8'b0000_1000};
    tbl[8]  = '{32'h00400000, 16'h0000, 8'b1100_0001};
    tbl[9]  = '{32'h80000000, 16'h8000, 8'b1000_0000};
    tbl[10] = '{32'h3F80FFFF, 16'h3F81, 8'b0000_0001};
    tbl[11] = '{32'hBF7FFFFF, 16'hBF80, 8'b0000_0001};
    tbl[12] = '{32'hFF7F8000, 16'hFF80, 8'b0010_0011};
    tbl[13] = '{32'h7F800000, 16'h7F80, 8'b0000_0100};
    tbl[14] = '{32'h3F800001, 16'h3F80, 8'b0000_0001};
    tbl[15] = '{32'h80000001, 16'h8000, 8'b1100_0001};
    tbl[16] = '{32'hFFC12345, 16'hFFC1, 8'b0001_0000};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_out_data", {16'h0, out_data}, 32'h0);
    chk("reset_flags", {24'h0, dut_flags()}, 32'h0);
    chk("reset_cnt", {16'h0, cnt_inexact}, 32'h0);
    @(posedge clk); #1;

    // two-cycle latency with empty pipe
    in_valid = 1'b1; in_data = tbl[0].in;
    @(negedge clk);
    chk("lat_in_ready", {31'h0, in_ready}, 32'h1);
    sb.push_back('{d: tbl[0].d, f: tbl[0].f});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("lat_cycle2_valid", {31'h0, out_valid}, 32'h1);
    drain();

    for (int i = 1; i <= 3; i++) send(tbl[i]);
    drain();
    chk("cnt_after_rne", {16'h0, cnt_inexact}, 32'd3);

    for (int i = 0; i < 17; i++) send(tbl[i]);
    drain();
    chk("cnt_after_table", {16'h0, cnt_inexact}, exp_cnt);

    // backpressure: only two accepted while output is stalled
    out_ready = 1'b0;
    send(tbl[2]);
    send(tbl[4]);
    in_valid = 1'b1; in_data = tbl[7].in;
    @(negedge clk);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_out_stable", {16'h0, out_data}, {16'h0, held});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(tbl[7]);
    send(tbl[12]);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_all_delivered", sb.size(), 32'h0);
    drain();
    chk("cnt_after_bp", {16'h0, cnt_inexact}, exp_cnt);

    // reset with two items in flight discards them
    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[5]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_cnt", {16'h0, cnt_inexact}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", {31'h0, out_valid}, 32'h0);
    end
    @(posedge clk); #1;

    send(tbl[3]);
    drain();
    chk("cnt_post_reset", {16'h0, cnt_inexact}, 32'd1);

    // clear collides with an inexact output transfer
    out_ready = 1'b0;
    send(tbl[10]);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_cnt = 0;
    chk("clr_priority_cnt", {16'h0, cnt_inexact}, 32'h0);
    chk("clr_delivered", sb.size(), 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
